// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rxd, majority-votes each bit at mid-period and
// presents completed bytes on a one-entry valid/ready holding register.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       rx_busy
);

  if (CLKS_PER_BIT < 16 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
    $error("uart_rx: CLKS_PER_BIT must be within 16..65535");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("uart_rx: SYNC_STAGES must be within 2..4");
  end

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_V0   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_V1   = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] CNT_DEC  = CW'(CLKS_PER_BIT / 2 + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          clk_cnt_q, clk_cnt_d, next_cnt;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic [1:0]             vote_q, vote_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_err_q, overrun_err_d;
  logic                   rx_busy_q, rx_busy_d;
  logic                   rxs, bit_val, at_dec, at_last, deliver;

  assign rxs = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    vote_d    = vote_q;
    sync_d    = {sync_q[SYNC_STAGES-2:0], rxd};
    deliver     = 1'b0;
    frame_err_d = 1'b0;
    at_dec   = (clk_cnt_q == CNT_DEC);
    at_last  = (clk_cnt_q == CNT_LAST);
    next_cnt = at_last ? '0 : clk_cnt_q + CNT_ONE;
    bit_val  = maj3(vote_q[0], vote_q[1], rxs);

    // The first two votes are latched; the third is the live sample at the decision count.
    if (clk_cnt_q == CNT_V0) begin
      vote_d[0] = rxs;
    end else if (clk_cnt_q == CNT_V1) begin
      vote_d[1] = rxs;
    end else begin
      vote_d = vote_q;
    end

    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = 3'd0;
        state_d   = rxs ? S_IDLE : S_START;
      end
      S_START: begin
        clk_cnt_d = next_cnt;
        if (at_dec && bit_val) begin
          clk_cnt_d = '0;
          state_d   = S_IDLE;
        end else if (at_last) begin
          bit_cnt_d = 3'd0;
          state_d   = S_DATA;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        clk_cnt_d = next_cnt;
        if (at_dec) begin
          shift_d = {bit_val, shift_q[7:1]};
        end else begin
          shift_d = shift_q;
        end
        if (at_last) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          state_d   = (bit_cnt_q == 3'd7) ? S_STOP : S_DATA;
        end else begin
          state_d = S_DATA;
        end
      end
      S_STOP: begin
        clk_cnt_d = next_cnt;
        if (at_dec) begin
          clk_cnt_d = '0;
          if (bit_val) begin
            deliver = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          state_d = S_STOP;
        end
      end
      S_BREAK: begin
        clk_cnt_d = '0;
        state_d   = rxs ? S_IDLE : S_BREAK;
      end
      default: begin
        clk_cnt_d = '0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // A full holding register only accepts a new byte if it is drained on the same edge.
  always_comb begin
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    overrun_err_d = 1'b0;
    if (deliver) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_err_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end
    rx_busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      sync_q        <= '1;
      clk_cnt_q     <= '0;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 8'h00;
      vote_q        <= 2'b00;
      rx_data_q     <= 8'h00;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
      rx_busy_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      clk_cnt_q     <= clk_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      vote_q        <= vote_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
      rx_busy_q     <= rx_busy_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
  assign rx_busy     = rx_busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: table of frames plus hand-written
// sequences for false start, framing error, break, overrun and mid-frame reset.
module tb_uart_rx;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun_err;
  logic       rx_busy;

  uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun_err(overrun_err), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         stop_len;
    bit         jitter;
    logic [7:0] exp_data;
  } frame_t;

  int cyc = 0;
  int total = 0;
  int passed = 0;
  int start_cyc = 0;

  // Monitor-owned counters; the test reads deltas against snapshots.
  logic [7:0] got[$];
  int fe_cnt = 0, ov_cnt = 0, valid_cyc = 0, busy_cyc = 0, both_cnt = 0, unstable_cnt = 0;
  int last_rise = 0;
  logic prev_valid = 1'b0, prev_ready = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && rx_ready) got.push_back(rx_data);
      if (frame_err) fe_cnt++;
      if (overrun_err) ov_cnt++;
      if (rx_valid) valid_cyc++;
      if (rx_busy) busy_cyc++;
      if (frame_err && overrun_err) both_cnt++;
      if (rx_valid && !prev_valid) last_rise = cyc;
      if (rx_valid && prev_valid && !prev_ready && rx_data !== prev_data) unstable_cnt++;
      prev_valid = rx_valid;
      prev_ready = rx_ready;
      prev_data  = rx_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_bit(input logic v, input int n);
    rxd = v;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input int stop_len, input bit jit);
    start_cyc = cyc;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) begin
      drive_bit(d[i], CPB + (jit ? ((i % 2 == 0) ? 1 : -1) : 0));
    end
    drive_bit(1'b1, stop_len);
  endtask

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual === expected) begin
      passed++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  frame_t frames[4];
  int gb, fe0, ov0, vc0, bc0, d;

  initial begin
    frames[0] = '{data: 8'hA3, stop_len: CPB,     jitter: 1'b0, exp_data: 8'hA3};
    frames[1] = '{data: 8'h00, stop_len: CPB - 4, jitter: 1'b1, exp_data: 8'h00};
    frames[2] = '{data: 8'hFF, stop_len: CPB - 4, jitter: 1'b1, exp_data: 8'hFF};
    frames[3] = '{data: 8'h80, stop_len: CPB - 4, jitter: 1'b1, exp_data: 8'h80};

    rst = 1'b1; rxd = 1'b1; rx_ready = 1'b1;
    repeat (3) tick();
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_overrun_err", overrun_err, 1'b0);
    check("reset_rx_busy", rx_busy, 1'b0);
    rst = 1'b0;
    repeat (5) tick();

    // Single 0x55 with latency window measured from the pin start edge.
    gb = got.size(); fe0 = fe_cnt; ov0 = ov_cnt; vc0 = valid_cyc;
    send_frame(8'h55, CPB, 1'b0);
    repeat (2 * CPB) tick();
    check("b55_count", got.size() - gb, 1);
    if (got.size() > gb) check("b55_data", got[gb], 8'h55);
    d = last_rise - start_cyc;
    check("b55_latency_window", (d >= 154 && d <= 158), 1'b1);
    check("b55_valid_width", valid_cyc - vc0, 1);
    check("b55_no_errs", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

    // Three-cycle glitch is a false start.
    gb = got.size(); fe0 = fe_cnt; bc0 = busy_cyc;
    rxd = 1'b0;
    repeat (3) tick();
    rxd = 1'b1;
    repeat (2 * CPB) tick();
    check("glitch_busy_seen", (busy_cyc - bc0) > 0, 1'b1);
    check("glitch_back_idle", rx_busy, 1'b0);
    check("glitch_no_byte", got.size() - gb, 0);
    check("glitch_no_ferr", fe_cnt - fe0, 0);

    // Table: 0xA3 after the glitch, then 0x00/0xFF/0x80 back-to-back with short stop and jitter.
    gb = got.size(); fe0 = fe_cnt; ov0 = ov_cnt;
    for (int i = 0; i < 4; i++) send_frame(frames[i].data, frames[i].stop_len, frames[i].jitter);
    repeat (2 * CPB) tick();
    check("table_count", got.size() - gb, 4);
    for (int i = 0; i < 4; i++) begin
      if (got.size() > gb + i) check($sformatf("table_byte%0d", i), got[gb + i], frames[i].exp_data);
    end
    check("table_no_errs", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

    // 0xA5 with a one-bit low stop, then released.
    gb = got.size(); fe0 = fe_cnt; vc0 = valid_cyc;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(((8'hA5 >> i) & 8'h01) != 8'h00, CPB);
    drive_bit(1'b0, CPB);
    drive_bit(1'b1, 2 * CPB);
    check("ferr_one_pulse", fe_cnt - fe0, 1);
    check("ferr_no_valid", valid_cyc - vc0, 0);
    check("ferr_no_byte", got.size() - gb, 0);

    // Line held low for 40 bit times.
    fe0 = fe_cnt;
    drive_bit(1'b0, 40 * CPB);
    check("break_busy", rx_busy, 1'b1);
    drive_bit(1'b1, 2 * CPB);
    check("break_one_pulse", fe_cnt - fe0, 1);
    check("break_idle_after", rx_busy, 1'b0);
    check("break_no_byte", got.size() - gb, 0);

    // Overrun: consumer stalled across two frames.
    rx_ready = 1'b0;
    gb = got.size(); fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'h11, CPB, 1'b0);
    send_frame(8'h22, CPB, 1'b0);
    repeat (2 * CPB) tick();
    check("ovr_valid_held", rx_valid, 1'b1);
    check("ovr_data_held", rx_data, 8'h11);
    check("ovr_one_pulse", ov_cnt - ov0, 1);
    check("ovr_no_ferr", fe_cnt - fe0, 0);
    check("ovr_data_stable", unstable_cnt, 0);
    rx_ready = 1'b1;
    tick();
    check("ovr_valid_drops", rx_valid, 1'b0);
    check("ovr_data_kept", rx_data, 8'h11);
    check("ovr_consumed_count", got.size() - gb, 1);
    if (got.size() > gb) check("ovr_consumed_byte", got[gb], 8'h11);

    // Reset mid bit 4 of 0x3C; the sender aborts the frame.
    gb = got.size(); fe0 = fe_cnt; ov0 = ov_cnt;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(((8'h3C >> i) & 8'h01) != 8'h00, CPB);
    drive_bit(1'b1, CPB / 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_busy", rx_busy, 1'b0);
    check("rst_pulses", {frame_err, overrun_err}, 2'b00);
    drive_bit(1'b1, 2 * CPB);
    check("rst_no_byte", got.size() - gb, 0);
    send_frame(8'hC3, CPB, 1'b0);
    repeat (2 * CPB) tick();
    check("post_rst_count", got.size() - gb, 1);
    if (got.size() > gb) check("post_rst_byte", got[gb], 8'hC3);
    check("post_rst_no_errs", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
    check("never_both_errs", both_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
